// File: rtl/texture_mapper_hls_fifo.sv
// ----------------------------------------------------------------------------
// texture_mapper_hls_fifo
//   Elastic first-word-fall-through ready/valid FIFO. It sits between the
//   texture mapper pipeline stages and the holding registers they load, and
//   absorbs producer bursts and consumer stalls. The head word is presented on
//   read_data while read_valid is high; no read request is needed to see it.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high; clears pointers, count and flags
//   write_valid  producer offers write_data
//   write_data   word to enqueue
//   write_ready  FIFO can accept a word this cycle (usedw != depth)
//   read_valid   read_data holds a valid head word (usedw != 0)
//   read_data    head word; don't-care while read_valid is low
//   read_ready   consumer takes the head word this cycle
//   usedw        number of stored words, 0..depth
//   almost_full  usedw >= af_threshold
// ----------------------------------------------------------------------------
module texture_mapper_hls_fifo #(
  parameter int unsigned width        = 32,
  parameter int unsigned addr_width   = 3,
  parameter int unsigned af_threshold = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_valid,
  input  logic [width-1:0]      write_data,
  output logic                  write_ready,
  output logic                  read_valid,
  output logic [width-1:0]      read_data,
  input  logic                  read_ready,
  output logic [addr_width:0]   usedw,
  output logic                  almost_full
);

  localparam int unsigned depth = 1 << addr_width;
  localparam int unsigned uw    = addr_width + 1;

  logic [width-1:0]      mem [depth];
  logic [addr_width-1:0] wr_ptr;
  logic [addr_width-1:0] rd_ptr;
  logic [addr_width-1:0] wr_ptr_nxt;
  logic [addr_width-1:0] rd_ptr_nxt;
  logic [uw-1:0]         usedw_nxt;
  logic                  push;
  logic                  pop;

  // Handshakes, pointer advance and occupancy update.
  // The flags are flops, so a push offered while full is simply not accepted,
  // even if a pop frees an entry in the same cycle.
  always_comb begin
    push       = write_valid & write_ready;
    pop        = read_valid & read_ready;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    usedw_nxt  = usedw;
    if (push) wr_ptr_nxt = wr_ptr + addr_width'(1);
    if (pop)  rd_ptr_nxt = rd_ptr + addr_width'(1);
    unique case ({push, pop})
      2'b10:   usedw_nxt = usedw + uw'(1);
      2'b01:   usedw_nxt = usedw - uw'(1);
      default: usedw_nxt = usedw;
    endcase
  end

  // State and status flags. The flags are computed from the next count, so
  // they always agree with the registered usedw.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      usedw       <= '0;
      write_ready <= 1'b1;
      read_valid  <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      usedw       <= usedw_nxt;
      write_ready <= (usedw_nxt != uw'(depth));
      read_valid  <= (usedw_nxt != '0);
      almost_full <= (usedw_nxt >= uw'(af_threshold));
    end
  end

  // Storage is not reset; a word is only visible once usedw covers it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= write_data;
  end

  // First-word-fall-through: the head entry is always on the output.
  assign read_data = mem[rd_ptr];

endmodule

// File: tb/tb_texture_mapper_hls_fifo.sv
// ----------------------------------------------------------------------------
// tb_texture_mapper_hls_fifo
//   Directed bench for texture_mapper_hls_fifo: a table of per-cycle vectors
//   (inputs plus the outputs expected just after the clock edge) and a few
//   hand-written sequences for reset, concurrent traffic and full+pop.
// ----------------------------------------------------------------------------
module tb_texture_mapper_hls_fifo;

  logic        clk;
  logic        reset;
  logic        write_valid;
  logic [31:0] write_data;
  logic        write_ready;
  logic        read_valid;
  logic [31:0] read_data;
  logic        read_ready;
  logic [3:0]  usedw;
  logic        almost_full;

  int errors;
  int checks;

  typedef struct {
    logic        wv;
    logic [31:0] wd;
    logic        rr;
    logic        rv;
    logic [31:0] rd;
    logic [3:0]  uw;
    logic        af;
    logic        wrdy;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] model_q[$];

  texture_mapper_hls_fifo #(
    .width(32),
    .addr_width(3),
    .af_threshold(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .write_valid(write_valid),
    .write_data(write_data),
    .write_ready(write_ready),
    .read_valid(read_valid),
    .read_data(read_data),
    .read_ready(read_ready),
    .usedw(usedw),
    .almost_full(almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic wv, input logic [31:0] wd, input logic rr,
                         input logic rv, input logic [31:0] rd, input int uw,
                         input logic wrdy);
    vec_t v;
    v.wv = wv; v.wd = wd; v.rr = rr;
    v.rv = rv; v.rd = rd; v.uw = 4'(uw);
    v.af = (uw >= 6);
    v.wrdy = wrdy;
    vecs.push_back(v);
  endtask

  // Drive inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic wv, input logic [31:0] wd, input logic rr);
    write_valid = wv;
    write_data  = wd;
    read_ready  = rr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    write_valid = 1'b0;
    write_data  = '0;
    read_ready  = 1'b0;
    reset       = 1'b1;

    // Vector table: fill with overflow attempt, drain, idle pop, latency.
    for (int i = 1; i <= 8; i++)
      add_vec(1'b1, 32'h10 + 32'(i), 1'b0, 1'b1, 32'h11, i, i != 8);
    add_vec(1'b1, 32'h19, 1'b0, 1'b1, 32'h11, 8, 1'b0);
    for (int k = 1; k <= 8; k++)
      add_vec(1'b0, 32'h0, 1'b1, k != 8, 32'h11 + 32'(k), 8 - k, 1'b1);
    add_vec(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 0, 1'b1);
    add_vec(1'b1, 32'hA5, 1'b0, 1'b1, 32'hA5, 1, 1'b1);
    add_vec(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 0, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    check("reset_rv", 32'(read_valid), 32'd0);
    check("reset_usedw", 32'(usedw), 32'd0);
    check("reset_af", 32'(almost_full), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_wready", 32'(write_ready), 32'd1);

    foreach (vecs[i]) begin
      step(vecs[i].wv, vecs[i].wd, vecs[i].rr);
      check($sformatf("vec%0d_usedw", i), 32'(usedw), 32'(vecs[i].uw));
      check($sformatf("vec%0d_rv", i), 32'(read_valid), 32'(vecs[i].rv));
      check($sformatf("vec%0d_af", i), 32'(almost_full), 32'(vecs[i].af));
      check($sformatf("vec%0d_wready", i), 32'(write_ready), 32'(vecs[i].wrdy));
      if (vecs[i].rv)
        check($sformatf("vec%0d_rdata", i), read_data, vecs[i].rd);
    end

    // Concurrent push/pop at usedw=4 for 20 cycles, crossing the pointer wrap.
    model_q.delete();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h40 + 32'(i), 1'b0);
      model_q.push_back(32'h40 + 32'(i));
    end
    check("conc_start_usedw", 32'(usedw), 32'd4);
    for (int i = 0; i < 20; i++) begin
      logic [31:0] exp_head;
      exp_head = model_q.pop_front();
      check($sformatf("conc%0d_head", i), read_data, exp_head);
      model_q.push_back(32'h44 + 32'(i));
      step(1'b1, 32'h44 + 32'(i), 1'b1);
      check($sformatf("conc%0d_usedw", i), 32'(usedw), 32'd4);
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_head;
      exp_head = model_q.pop_front();
      check($sformatf("conc_drain%0d", i), read_data, exp_head);
      step(1'b0, 32'h0, 1'b1);
    end
    check("conc_end_usedw", 32'(usedw), 32'd0);
    check("conc_end_rv", 32'(read_valid), 32'd0);

    // Full + pop: the offered write is refused while full, accepted next cycle.
    for (int i = 0; i < 8; i++) step(1'b1, 32'h60 + 32'(i), 1'b0);
    check("fp_full_usedw", 32'(usedw), 32'd8);
    check("fp_full_wready", 32'(write_ready), 32'd0);
    step(1'b1, 32'hBE, 1'b1);
    check("fp_pop_only_usedw", 32'(usedw), 32'd7);
    check("fp_pop_only_head", read_data, 32'h61);
    step(1'b1, 32'hBE, 1'b0);
    check("fp_accept_usedw", 32'(usedw), 32'd8);
    for (int i = 1; i < 8; i++) begin
      check($sformatf("fp_drain%0d", i), read_data, 32'h60 + 32'(i));
      step(1'b0, 32'h0, 1'b1);
    end
    check("fp_last_word", read_data, 32'hBE);
    step(1'b0, 32'h0, 1'b1);
    check("fp_empty_rv", 32'(read_valid), 32'd0);

    // Reset asserted mid-cycle with three words stored.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h70 + 32'(i), 1'b0);
    write_valid = 1'b0;
    check("mid_reset_pre_usedw", 32'(usedw), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset_rv", 32'(read_valid), 32'd0);
    check("mid_reset_usedw", 32'(usedw), 32'd0);
    check("mid_reset_af", 32'(almost_full), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset_wready", 32'(write_ready), 32'd1);
    check("mid_reset_rv_after", 32'(read_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
